clock_time_ctrl: RTL and testbench



---
 rtl/clock_time_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: MM:SS timekeeping and time-set controller.
//   Debounces the mode/up/down buttons, runs the RUN / SET_MIN / SET_SEC
//   FSM, owns the 1 Hz prescaler, the sec/min counters and the edit-field
//   blink phase.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   btn_mode/up/down   raw asynchronous active-high buttons
//   sec, min           binary time, each 0..59
//   mode               00 RUN, 01 SET_MIN, 10 SET_SEC
//   tick_1hz           one-cycle pulse per elapsed second (RUN only)
//   blank_min/sec      blank request for the field being edited
// All outputs are registered.

// Per-button lane: 2-FF synchroniser, debounce counter, stable level and
// a one-cycle press pulse on the stable 0->1 transition.
module btn_deb #(
  parameter int DEB_CYCLES = 1250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          s1, s2, stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        stable <= s2;
        cnt    <= '0;
        press  <= s2;  // only a rising stable level produces a press
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module clock_time_ctrl #(
  parameter int CLK_HZ     = 125000000,
  parameter int DEB_CYCLES = 1250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [1:0] mode,
  output logic       tick_1hz,
  output logic       blank_min,
  output logic       blank_sec
);
  localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HALF = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_SEC = 2'b10
  } state_t;

  // press[0]=mode, press[1]=up, press[2]=down
  logic [2:0] press;

  btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [2:0] (
    .clk  (clk),
    .rst  (rst),
    .raw  ({btn_down, btn_up, btn_mode}),
    .press(press)
  );

  state_t        st, st_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [HW-1:0] bcnt, bcnt_n;
  logic          phase, phase_n;
  logic [5:0]    sec_n, min_n;
  logic          tick_n;
  logic          p_mode, p_up, p_dn;

  assign p_mode = press[0];
  // Simultaneous up+down cancel each other.
  assign p_up   = press[1] & ~press[2];
  assign p_dn   = press[2] & ~press[1];

  always_comb begin
    st_n    = st;
    sec_n   = sec;
    min_n   = min;
    pcnt_n  = pcnt;
    bcnt_n  = bcnt;
    phase_n = phase;
    tick_n  = 1'b0;
    case (st)
      RUN: begin
        if (p_mode) begin
          st_n    = SET_MIN;
          pcnt_n  = '0;
          bcnt_n  = '0;
          phase_n = 1'b0;
        end else if (pcnt == PW'(CLK_HZ - 1)) begin
          pcnt_n = '0;
          tick_n = 1'b1;
          if (sec != 6'd59) begin
            sec_n = sec + 6'd1;
          end else begin
            sec_n = 6'd0;
            min_n = (min == 6'd59) ? 6'd0 : min + 6'd1;
          end
        end else begin
          pcnt_n = pcnt + 1'b1;
        end
      end
      SET_MIN, SET_SEC: begin
        // Time is frozen while editing; prescaler parked at 0 so RUN
        // resumes with a full second.
        pcnt_n = '0;
        if (p_mode) begin
          st_n    = (st == SET_MIN) ? SET_SEC : RUN;
          bcnt_n  = '0;
          phase_n = 1'b0;
        end else begin
          if (bcnt == HW'(HALF - 1)) begin
            bcnt_n  = '0;
            phase_n = ~phase;
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
          if (st == SET_MIN) begin
            if (p_up) min_n = (min == 6'd59) ? 6'd0  : min + 6'd1;
            if (p_dn) min_n = (min == 6'd0)  ? 6'd59 : min - 6'd1;
          end else begin
            if (p_up) sec_n = (sec == 6'd59) ? 6'd0  : sec + 6'd1;
            if (p_dn) sec_n = (sec == 6'd0)  ? 6'd59 : sec - 6'd1;
          end
        end
      end
      default: st_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= RUN;
      sec       <= '0;
      min       <= '0;
      pcnt      <= '0;
      bcnt      <= '0;
      phase     <= 1'b0;
      tick_1hz  <= 1'b0;
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
    end else begin
      st        <= st_n;
      sec       <= sec_n;
      min       <= min_n;
      pcnt      <= pcnt_n;
      bcnt      <= bcnt_n;
      phase     <= phase_n;
      tick_1hz  <= tick_n;
      // Blank flags are derived from next-state values so they stay
      // cycle-aligned with mode.
      blank_min <= (st_n == SET_MIN) & phase_n;
      blank_sec <= (st_n == SET_SEC) & phase_n;
    end
  end

  assign mode = st;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with CLK_HZ=10, DEB_CYCLES=4.
module tb_clock_time_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [5:0] sec, min;
  logic [1:0] mode;
  logic       tick_1hz, blank_min, blank_sec;

  int n_cmp = 0;
  int n_bad = 0;

  clock_time_ctrl #(.CLK_HZ(10), .DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .sec(sec), .min(min), .mode(mode), .tick_1hz(tick_1hz),
    .blank_min(blank_min), .blank_sec(blank_sec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btn;   // {down, up, mode}
    logic [1:0] md;
    logic [5:0] mn;
    logic [5:0] sc;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // Hold the given buttons, release, and wait long enough for the release
  // to debounce. The FSM acts 7 edges after the buttons go high.
  task automatic press(input logic [2:0] b, input int hold);
    {btn_down, btn_up, btn_mode} = b;
    step(hold);
    {btn_down, btn_up, btn_mode} = 3'b000;
    step(8);
  endtask

  initial begin
    tbl[0] = '{3'b001, 2'd1, 6'd0,  6'd0};   // mode -> SET_MIN
    tbl[1] = '{3'b100, 2'd1, 6'd59, 6'd0};   // down wraps min 0->59
    tbl[2] = '{3'b010, 2'd1, 6'd0,  6'd0};   // up wraps min 59->0
    tbl[3] = '{3'b100, 2'd1, 6'd59, 6'd0};
    tbl[4] = '{3'b110, 2'd1, 6'd59, 6'd0};   // up+down cancel
    tbl[5] = '{3'b001, 2'd2, 6'd59, 6'd0};   // -> SET_SEC
    tbl[6] = '{3'b100, 2'd2, 6'd59, 6'd59};  // sec 0->59, no borrow
    tbl[7] = '{3'b010, 2'd2, 6'd59, 6'd0};   // sec 59->0, no carry
    tbl[8] = '{3'b100, 2'd2, 6'd59, 6'd59};
    tbl[9] = '{3'b011, 2'd0, 6'd59, 6'd59};  // mode wins over up

    // Reset state and free-running seconds
    do_reset();
    check("rst_sec", sec, 0);
    check("rst_min", min, 0);
    check("rst_mode", mode, 0);
    check("rst_tick", tick_1hz, 0);
    check("rst_bmin", blank_min, 0);
    check("rst_bsec", blank_sec, 0);
    for (int i = 1; i <= 30; i++) begin
      step(1);
      check($sformatf("tick_c%0d", i), tick_1hz, (i % 10 == 0) ? 1 : 0);
      if (i % 10 == 0) check($sformatf("sec_c%0d", i), sec, i / 10);
    end
    check("run_min", min, 0);
    check("run_mode", mode, 0);
    check("run_blank", {blank_min, blank_sec}, 0);

    // Glitch rejection, single press, no auto-repeat
    do_reset();
    press(3'b001, 3);
    check("glitch_mode", mode, 0);
    press(3'b001, 6);
    check("press_mode", mode, 1);
    press(3'b001, 30);
    check("hold_mode", mode, 2);

    // Table-driven edit sequence
    do_reset();
    for (int i = 0; i < 10; i++) begin
      press(tbl[i].btn, 6);
      check($sformatf("v%0d_mode", i), mode, tbl[i].md);
      check($sformatf("v%0d_min", i), min, tbl[i].mn);
      check($sformatf("v%0d_sec", i), sec, tbl[i].sc);
    end
    // RUN entered 7 cycles ago; tick lands exactly 10 cycles after entry
    step(2);
    check("wrap_pre_tick", tick_1hz, 0);
    check("wrap_pre_sec", sec, 59);
    step(1);
    check("wrap_tick", tick_1hz, 1);
    check("wrap_sec", sec, 0);
    check("wrap_min", min, 0);

    // Blink phase in SET_MIN: toggles every 5 cycles from entry
    do_reset();
    press(3'b001, 6);
    check("blk_bmin_a", blank_min, 1);
    check("blk_bsec_a", blank_sec, 0);
    step(3);
    check("blk_bmin_b", blank_min, 0);
    step(5);
    check("blk_bmin_c", blank_min, 1);
    press(3'b010, 6);
    check("blk_min_up", min, 1);
    press(3'b001, 6);
    check("blk_mode_sec", mode, 2);
    check("blk_bsec_d", blank_sec, 1);
    check("blk_bmin_d", blank_min, 0);

    // Reset mid-edit takes priority and restarts the prescaler
    do_reset();
    check("mid_rst_mode", mode, 0);
    check("mid_rst_min", min, 0);
    check("mid_rst_sec", sec, 0);
    check("mid_rst_blank", {blank_min, blank_sec}, 0);
    step(9);
    check("mid_rst_notick", tick_1hz, 0);
    step(1);
    check("mid_rst_tick", tick_1hz, 1);
    check("mid_rst_sec1", sec, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
